// File: rtl/pc_pkg.sv
// pc_pkg: shared state/source enums and alignment helper for the PC unit
package pc_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  typedef enum logic [2:0] {SRC_HOLD, SRC_SEQ, SRC_REDIR, SRC_TRAP, SRC_MRET, SRC_MISALIGN} pc_src_t;
  function automatic logic [63:0] align_mask(input int unsigned bytes);
    return 64'(bytes - 1);
  endfunction
endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control inputs and fetch-PC outputs of the PC unit
interface pc_unit_if #(parameter int XLEN = 64);
  logic            pc_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            mret_valid;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic            pc_valid;
  logic [XLEN-1:0] epc_out;
  logic            misalign;
  logic            halted;
  modport master (
    output pc_write, redirect_valid, redirect_target, trap_valid, trap_vector, mret_valid, halt_req, resume,
    input  pc_out, pc_valid, epc_out, misalign, halted
  );
  modport slave (
    input  pc_write, redirect_valid, redirect_target, trap_valid, trap_vector, mret_valid, halt_req, resume,
    output pc_out, pc_valid, epc_out, misalign, halted
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: priority-encodes the PC source and muxes next PC/EPC/misalign
module pc_next_sel import pc_pkg::*; #(
  parameter int          XLEN       = 64,
  parameter int unsigned INST_BYTES = 4
) (
  input  logic            run,
  input  logic            halt,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic            trap_valid,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] epc,
  input  logic [XLEN-1:0] redirect_target,
  input  logic [XLEN-1:0] trap_vector,
  output pc_src_t         src,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] next_epc,
  output logic            next_misalign
);
  localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(INST_BYTES));
  logic aligned;
  assign aligned = (redirect_target & MASK) == '0;
  // only traps reach the PC while halted; nothing does during boot
  always_comb begin
    src = (trap_valid && (run || halt)) ? SRC_TRAP :
          !run                          ? SRC_HOLD :
          mret_valid                    ? SRC_MRET :
          redirect_valid                ? (aligned ? SRC_REDIR : SRC_MISALIGN) :
          pc_write                      ? SRC_SEQ : SRC_HOLD;
    next_pc = (src == SRC_TRAP || src == SRC_MISALIGN) ? trap_vector :
              src == SRC_MRET  ? epc :
              src == SRC_REDIR ? redirect_target :
              src == SRC_SEQ   ? pc + XLEN'(INST_BYTES) : pc;
    next_epc = src == SRC_TRAP ? pc : src == SRC_MISALIGN ? redirect_target : epc;
    next_misalign = src == SRC_MISALIGN;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC, EPC and boot/run/halt sequencing for the IF stage
module pc_unit import pc_pkg::*; #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INST_BYTES   = 4
) (
  input logic       clk,
  input logic       rst,
  pc_unit_if.slave  bus
);
  state_t          state, nstate;
  pc_src_t         src;
  logic [XLEN-1:0] pc, epc, next_pc, next_epc;
  logic            next_misalign, misalign, pc_valid, halted;
  pc_next_sel #(.XLEN(XLEN), .INST_BYTES(INST_BYTES)) u_sel (
    .run(state == RUN), .halt(state == HALT),
    .pc_write(bus.pc_write), .redirect_valid(bus.redirect_valid),
    .trap_valid(bus.trap_valid), .mret_valid(bus.mret_valid),
    .pc(pc), .epc(epc), .redirect_target(bus.redirect_target), .trap_vector(bus.trap_vector),
    .src(src), .next_pc(next_pc), .next_epc(next_epc), .next_misalign(next_misalign)
  );
  // a halt request still lets this edge's PC update through; halt+resume stays halted
  always_comb begin
    nstate = state == BOOT ? RUN :
             state == RUN  ? (bus.halt_req ? HALT : RUN) :
             (src == SRC_TRAP || (bus.resume && !bus.halt_req)) ? RUN : HALT;
  end
  // all outputs are registered so nothing leaks combinationally from the inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      epc      <= '0;
      misalign <= 1'b0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= nstate;
      pc       <= next_pc;
      epc      <= next_epc;
      misalign <= next_misalign;
      pc_valid <= nstate == RUN;
      halted   <= nstate == HALT;
    end
  end
  assign bus.pc_out   = pc;
  assign bus.epc_out  = epc;
  assign bus.misalign = misalign;
  assign bus.pc_valid = pc_valid;
  assign bus.halted   = halted;
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the pipelined RISC-V core. It replaces the plain PC register at the front of the IF stage.
- Holds the fetch PC and computes the sequential next PC internally.
- Arbitrates redirect sources: trap, trap-return and branch/jump.
- Keeps an exception PC (EPC), sequences a boot/run/halt state machine and flags misaligned redirect targets. Feeds instruction memory and the IF/ID register.

Parameters:
- XLEN, 64, PC and target width in bits.
- RESET_VECTOR, 64'h0, PC value loaded by reset.
- INST_BYTES, 4, sequential increment; must be a power of two ≥ 2. Also the alignment checked on redirects.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_write  input  1  advance enable from hazard unit (0 = stall, hold PC).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  XLEN  branch/jump destination.
- trap_valid  input  1  exception/interrupt taken.
- trap_vector  input  XLEN  trap handler address (caller guarantees alignment).
- mret_valid  input  1  return from trap.
- halt_req  input  1  request to freeze fetch.
- resume  input  1  leave HALT.
- pc_out  output  XLEN  current fetch PC.
- pc_valid  output  1  pc_out is a legal fetch address this cycle.
- epc_out  output  XLEN  saved exception PC.
- misalign  output  1  one-cycle pulse, misaligned redirect trapped.
- halted  output  1  state == HALT.

Behaviour:
- Reset: synchronous and active-high; sampled only on a clk rising edge. When rst=1 at an edge, the next values are:
  - pc_out=RESET_VECTOR
  - epc_out=0
  - misalign=0
  - state=BOOT
  - pc_valid=0 and halted=0
- Reset wins over every other input, including mid-trap or mid-halt.
- States: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle; pc_out holds RESET_VECTOR and pc_valid=0. Next state is RUN unconditionally; all other inputs are ignored.
  - RUN: pc_valid=1. PC update priority at each edge, highest first:
    1. trap_valid: epc<=pc_out, pc<=trap_vector.
    2. mret_valid: pc<=epc_out; epc unchanged.
    3. redirect_valid with target aligned: pc<=redirect_target.
    4. redirect_valid with target[log2(INST_BYTES)-1:0]≠0: pc<=trap_vector, epc<=redirect_target, misalign<=1 for the next cycle only.
    5. pc_write=1: pc<=pc_out+INST_BYTES, modulo 2^XLEN (wraps all-ones region to low addresses, no flag).
    6. else hold.
  - Sources 1–4 override a stall (pc_write=0).
  - If halt_req=1 in RUN, the PC update above still occurs this edge, then state<=HALT.
  - HALT: pc_valid=0, halted=1, and PC/EPC are frozen; pc_write and redirect_valid are ignored.
    - trap_valid is still honoured: it updates PC/EPC and returns to RUN.
    - Otherwise resume=1 returns to RUN at the next edge.
    - If halt_req and resume are both 1 in HALT, stay in HALT.
- misalign is registered and cleared every cycle it is not set.
- No combinational path from inputs to pc_out, epc_out, pc_valid, halted or misalign; all are register outputs.
- Latency: a redirect asserted in cycle N appears on pc_out in cycle N+1.

Decomposition:
- Shared package pc_pkg holds:
  - the state enum {BOOT, RUN, HALT}
  - the PC-source select enum {SRC_HOLD, SRC_SEQ, SRC_REDIR, SRC_TRAP, SRC_MRET, SRC_MISALIGN}
  - the alignment-mask helper function
- One natural sub-module: pc_next_sel, a combinational priority encoder plus next-PC mux producing the source select, next PC, next EPC and misalign. pc_unit keeps the registers and FSM.

Test Plan:
1. Boot and sequential fetch. Stimulus: XLEN=64, RESET_VECTOR=64'h1000, rst high 2 cycles, then pc_write=1. Required: one cycle with pc=1000 and pc_valid=0, then pc_valid=1 with pc=1000, 1004, 1008.
2. Stall versus branch. Stimulus: pc=2000, pc_write=0 for 3 cycles, then redirect_valid=1 with target 3000 while still stalled. Required: pc holds 2000 for 3 cycles, then pc=3000.
3. Trap/mret round-trip and priority. Stimulus: pc=4010, trap_valid=1 together with redirect_valid=1 (target 5000) and trap_vector=8000, then later mret_valid=1. Required: pc=8000 and epc=4010; after mret, pc=4010.
4. Misaligned redirect. Stimulus: redirect_target=6002, trap_vector=8000. Required: pc=8000, epc=6002, misalign high for exactly one cycle.
5. Halt behaviour. Stimulus: halt_req in RUN at pc=100 with pc_write=1; then in HALT apply redirect_valid, then resume. Required:
   - pc=104 and halted=1 at the next edge, with pc_valid=0.
   - The redirect in HALT is ignored.
   - After resume, pc_valid=1 with pc=104.
6. Wrap-around and reset in HALT. Stimulus: pc=FFFF_FFFF_FFFF_FFFC with pc_write=1; separately, rst asserted while in HALT. Required: pc wraps to 0 with no flag; the reset returns to BOOT with pc=RESET_VECTOR and epc=0.
